// File: rtl/denise_pkg.sv
// Shared definitions for the Denise register-bus master.
// Contents: idle RGA code, Denise register addresses (RGA[8:1]), slot FSM
// state encoding and the queued request record.
package denise_pkg;

  // Idle RGA code. It addresses register 0x1FE, which the target treats as a no-op.
  localparam logic [7:0] RGA_IDLE_ADDR = 8'hFF;

  // Register addresses, bits [8:1]
  localparam logic [7:0] BPLCON0  = 8'h80;
  localparam logic [7:0] COLOR00  = 8'hC0;
  localparam logic [7:0] DENISEID = 8'h3E;
  localparam logic [7:0] CLXDAT   = 8'h07;
  localparam logic [7:0] JOY0DAT  = 8'h05;
  localparam logic [7:0] JOY1DAT  = 8'h06;

  // Slot FSM: one pass through ADDR, DATA and HOLD takes one CCK period.
  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_ADDR_ENC = 2'd1;
  localparam logic [1:0] ST_DATA_ENC = 2'd2;
  localparam logic [1:0] ST_HOLD_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_ADDR = ST_ADDR_ENC,
    ST_DATA = ST_DATA_ENC,
    ST_HOLD = ST_HOLD_ENC
  } slot_state_t;

  // Queued request: 25 bits wide, laid out as {rd, addr, data}.
  typedef struct packed {
    logic        rd;
    logic [7:0]  addr;
    logic [15:0] data;
  } rga_req_t;

endpackage

// File: rtl/rga_bus_master_if.sv
// Request/response handshake of the register-bus master.
// modport master: the requester (it drives req_*, samples ready and rsp).
// modport slave : the bus master block (it samples req_*, drives ready and rsp).
interface rga_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rd;
  logic [7:0]  req_addr;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;

  modport master (output req_valid, req_rd, req_addr, req_data,
                  input  req_ready, rsp_valid, rsp_data);
  modport slave  (input  req_valid, req_rd, req_addr, req_data,
                  output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/rga_req_fifo.sv
// Synchronous request FIFO. Each entry is one rga_req_t record, {rd, addr, data}.
// Ports: clk, rst_n (async low), push/wr_req (write side), pop/head (read side;
//        head shows the oldest entry), full, empty.
// push is ignored when the FIFO is full. pop is ignored when it is empty.
module rga_req_fifo
  import denise_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  rga_req_t wr_req,
  input  logic     pop,
  output rga_req_t head,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);

  rga_req_t        mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     cnt;
  logic            do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Entries are left out of reset. Only the pointers and the count define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wr_req;
  end

  // The pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/rga_bus_master.sv
// Register-bus initiator for Denise. Runs one RGA/DB access per CCK period.
// A slot starts on a CCK rise. Write data is driven from CCKQ, and read data
// is sampled on the CCK fall.
// Ports: clk, rst_n (async low); cck, cck_edge, cckq_edge (strobes, synchronous to clk);
//        bus (rga_bus_master_if.slave: req_valid/ready/rd/addr/data, rsp_valid/data);
//        rga_out, db_out, db_oen, db_in (target side); busy.
// Build option: RGA_BUS_MASTER_READ_EN enables the read path. Without it, a read
// request uses its slot without driving RGA, and it completes with rsp_data 16'hFFFF.
module rga_bus_master
  import denise_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] RGA_IDLE   = RGA_IDLE_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cck,
  input  logic              cck_edge,
  input  logic              cckq_edge,
  rga_bus_master_if.slave   bus,
  output logic [7:0]        rga_out,
  output logic [15:0]       db_out,
  output logic              db_oen,
  input  logic [15:0]       db_in,
  output logic              busy
);
  slot_state_t state;
  rga_req_t    head, wr_req;
  logic        full, empty, rise, fall, pop;
  logic        cur_rd;
  logic [15:0] cur_data;
  logic        rsp_valid_q;
  logic [15:0] rsp_data_q;
  logic [7:0]  slot_rga;
  logic [15:0] rd_val;

  assign rise   = cck_edge && cck;
  assign fall   = cck_edge && !cck;
  assign wr_req = '{rd: bus.req_rd, addr: bus.req_addr, data: bus.req_data};

  // A new slot can start only on a rise, and only from IDLE or from the end of
  // the previous slot. This keeps the rate to one access per CCK period.
  assign pop = rise && !empty && (state == ST_IDLE || state == ST_HOLD);

  assign bus.req_ready = !full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state != ST_IDLE) || !empty;

`ifdef RGA_BUS_MASTER_READ_EN
  assign slot_rga = head.addr;
  assign rd_val   = db_in;
`else
  // Read path removed: a read slot leaves RGA idle and returns all ones.
  logic unused_db_in;
  assign unused_db_in = ^db_in;
  assign slot_rga     = head.rd ? RGA_IDLE : head.addr;
  assign rd_val       = 16'hFFFF;
`endif

  rga_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (bus.req_valid),
    .wr_req (wr_req),
    .pop    (pop),
    .head   (head),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rga_out     <= RGA_IDLE;
      db_out      <= '0;
      db_oen      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cur_rd      <= 1'b0;
      cur_data    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        ST_IDLE: if (pop) begin
          cur_rd   <= head.rd;
          cur_data <= head.data;
          rga_out  <= slot_rga;
          state    <= ST_ADDR;
        end
        ST_ADDR: if (cckq_edge) begin
          if (!cur_rd) begin
            db_out <= cur_data;
            db_oen <= 1'b1;
          end
          state <= ST_DATA;
        end
        ST_DATA: if (fall) begin
          if (cur_rd) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rd_val;
          end
          state <= ST_HOLD;
        end
        ST_HOLD: if (rise) begin
          db_oen <= 1'b0;
          db_out <= '0;
          // When another request is queued, start it back-to-back with no idle slot in between.
          if (pop) begin
            cur_rd   <= head.rd;
            cur_data <= head.data;
            rga_out  <= slot_rga;
            state    <= ST_ADDR;
          end else begin
            rga_out <= RGA_IDLE;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
